uart_txrx: RTL and testbench
============================

// Module: uart_txrx
// PURPOSE
//   Byte-wide 8N1 serial transceiver (one RX path, one TX path) sharing one clock.
//   Feeds the SoC peripheral UART holding registers and drives/receives the board debug UART pins.
//   The host side uses valid/ready handshakes; the line side is LSB-first async serial.
// PARAMETERS
//   CLK_FRE    30      clock frequency in MHz
//   BAUD_RATE  115200  line bit rate; CYCLE = CLK_FRE*1_000_000/BAUD_RATE, truncated (260 at defaults)
// PORTS
//   clk            in   1  system clock; all logic on posedge
//   rst_n          in   1  reset; one clock, asynchronous, active-low
//   rx_pin         in   1  serial input, asynchronous to clk, idle high
//   rx_data        out  8  last received byte
//   rx_data_valid  out  1  rx_data holds a new byte
//   rx_data_ready  in   1  host accepts byte (may be tied 1)
//   tx_data        in   8  byte to send
//   tx_data_valid  in   1  tx_data offered
//   tx_data_ready  out  1  transmitter idle; also used as "TX empty" status
//   tx_pin         out  1  serial output, idle high
// BEHAVIOUR
//   Reset (async assert, sync release): tx_pin=1, tx_data_ready=1, rx_data=0, rx_data_valid=0, FSMs idle, counters 0.
//   Reset mid-frame aborts immediately; tx_pin returns to 1 in the reset cycle; no partial byte delivered.
//   Frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly CYCLE clocks.
//   TX FSM: IDLE -> START -> DATA(bit 0..7) -> STOP -> IDLE.
//     IDLE: tx_pin=1, tx_data_ready=1. tx_data_valid&&tx_data_ready = accept: latch tx_data,
//     next cycle tx_data_ready=0 and tx_pin=0 (START).
//     Bit counter 0..CYCLE-1 per bit; wrap advances bit. After STOP's CYCLE clocks -> IDLE, ready=1.
//     Total busy time 10*CYCLE clocks. tx_data_valid while ready=0 is ignored (no queue).
//     tx_data may change after accept without effect.
//   RX: rx_pin passes 2-FF synchronizer (2-clock latency) before use.
//   RX FSM: IDLE -> START -> DATA -> STOP -> OUT -> IDLE.
//     IDLE: falling edge of synchronized input -> START.
//     START: sample at CYCLE/2 clocks; if 1 -> glitch, back to IDLE; else continue.
//     DATA: sample each bit at its centre (every CYCLE clocks after start centre), shift in LSB first.
//     STOP: sample at stop-bit centre; 1 -> OUT; 0 -> framing error, byte discarded, go IDLE
//       (waiting for line high before re-arming edge detect).
//     OUT: rx_data loaded, rx_data_valid=1; held until rx_data_ready=1, then cleared next cycle -> IDLE.
//       With ready tied 1 rx_data_valid is a single-cycle pulse.
//     Start bits arriving while in OUT are not detected (byte lost).
//     rx_data holds its value after valid drops.
//   Counters sized $clog2(CYCLE)+1; no arithmetic overflow at any legal parameter set (CYCLE>=4).
//   TX and RX fully independent; simultaneous activity allowed (loopback rx_pin<-tx_pin works).
// STRUCTURE
//   Package uart_pkg: tx_state_t / rx_state_t enums, function cycles_per_bit(clk_mhz, baud).
//   One sub-module: uart_sync2 (2-FF synchronizer with async active-low reset to 1) for rx_pin.
//   TX and RX FSMs live in this module as separate always_ff groups.
// TESTING (CLK_FRE=30, BAUD_RATE=115200, CYCLE=260)
//   Reset asserted mid-TX -> tx_pin=1, tx_data_ready=1, rx_data_valid=0 in the same cycle.
//   Send 0xA5 (valid 1 clk) -> ready=0 next clk; tx_pin 0, then 1,0,1,0,0,1,0,1, 1, each 260 clk;
//     ready=1 after 2600 clk.
//   Drive 0x3C on rx_pin at 260 clk/bit, ready=1 -> rx_data=0x3C, one-cycle valid ~2 clk after stop-bit centre.
//   100-clk low glitch on rx_pin -> no valid; following 0x81 frame received correctly.
//   Frame with stop bit 0 -> no valid; next frame 0x55 received as 0x55.
//   Loopback tx_pin->rx_pin, send 0x00 then 0xFF back-to-back, rx_data_ready=0 -> valid stays 1 with 0x00;
//     0xFF lost; after ready=1 valid clears next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and bit-timing helper for the 8N1 UART
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_OUT
  } rx_state_t;

  // Clocks per serial bit, truncated; widened so high clock rates cannot overflow
  function automatic int cycles_per_bit(input int clk_mhz, input int baud);
    return int'((64'(clk_mhz) * 64'd1000000) / 64'(baud));
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for the asynchronous serial input, resets to idle-high
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw input through two stages
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Synchronizer flops; reset to 1 so an idle line never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_txrx.sv
// rtl/uart_txrx.sv - 8N1 serial transceiver with valid/ready host side and independent TX/RX FSMs
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 30,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ready,
  output logic       tx_pin
);

  localparam int CYCLE = cycles_per_bit(CLK_FRE, BAUD_RATE);
  localparam int CW    = $clog2(CYCLE) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CYCLE / 2 - 1);

  // ---------------- TX path ----------------
  tx_state_t       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_pin_q, tx_pin_d;

  // TX next state: accept in IDLE, then hold each bit for CYCLE clocks; pin follows the next state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_data_valid) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q + CW'(1);
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else tx_cnt_d = tx_cnt_q + CW'(1);
      end
      default: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q + CW'(1);
      end
    endcase
    case (tx_state_d)
      TX_START: tx_pin_d = 1'b0;
      TX_DATA:  tx_pin_d = tx_shift_d[tx_bit_d];
      default:  tx_pin_d = 1'b1;
    endcase
  end

  // TX registers; the pin is registered so it never glitches between bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_pin_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_pin_q   <= tx_pin_d;
    end
  end

  assign tx_pin        = tx_pin_q;
  assign tx_data_ready = (tx_state_q == TX_IDLE);

  // ---------------- RX path ----------------
  logic            rx_sync;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_prev_q, rx_prev_d;

  uart_sync2 u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_pin),
    .q     (rx_sync)
  );

  // RX next state: edge-triggered start, mid-bit sampling, stop-bit validation, hold until taken
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_prev_d  = rx_sync;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else rx_cnt_d = rx_cnt_q + CW'(1);
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + CW'(1);
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync) begin
            rx_state_d = RX_OUT;
            rx_data_d  = rx_shift_q;
          end else rx_state_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt_q + CW'(1);
      end
      RX_OUT: begin
        if (rx_data_ready) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX registers; edge history resets high to match the idle line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_prev_q  <= rx_prev_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_valid = (rx_state_q == RX_OUT);

endmodule

// File: tb/tb_uart_txrx.sv
// tb/tb_uart_txrx.sv - scoreboard bench for uart_txrx with line-level TX decoder and RX frame driver
`timescale 1ns/1ps
module tb_uart_txrx;

  localparam int CYC = 260;

  logic       clk;
  logic       rst_n;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic       tx_pin;

  logic       rx_drv;
  logic       loopback;
  logic       tx_mon_en;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_centre_cyc = 0;
  int valid_rise_cyc = 0;
  int hi_len = 0;
  int last_pulse_len = 0;
  logic rx_prev_valid = 1'b0;
  logic [7:0] tx_got;
  logic [7:0] exp_b;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  assign rx_pin = loopback ? tx_pin : rx_drv;

  uart_txrx #(.CLK_FRE(30), .BAUD_RATE(115200)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .tx_pin        (tx_pin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line-level receiver model of the TX pin: samples each bit at its centre
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (tx_mon_en && rst_n && tx_pin == 1'b0) begin
        repeat (CYC / 2) @(negedge clk);
        #2;
        check("tx_start_bit", int'(tx_pin), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CYC) @(negedge clk);
          #2;
          tx_got[i] = tx_pin;
        end
        repeat (CYC) @(negedge clk);
        #2;
        check("tx_stop_bit", int'(tx_pin), 1);
        check("tx_frame_expected", int'(tx_q.size() > 0), 1);
        if (tx_q.size() > 0) begin
          exp_b = tx_q.pop_front();
          check("tx_byte", int'(tx_got), int'(exp_b));
        end
      end
    end
  end

  // Host-side RX monitor: pops the scoreboard on each accepted byte, tracks pulse timing
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && rx_data_valid) begin
        if (!rx_prev_valid) valid_rise_cyc = cyc;
        hi_len++;
        if (rx_data_ready) begin
          check("rx_byte_expected", int'(rx_q.size() > 0), 1);
          if (rx_q.size() > 0) check("rx_byte", int'(rx_data), int'(rx_q.pop_front()));
        end
      end else begin
        if (rx_prev_valid) last_pulse_len = hi_len;
        hi_len = 0;
      end
      rx_prev_valid = rx_data_valid;
    end
  end

  task automatic tx_send(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_data_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", int'(tx_data_ready), 1);
    tx_data       = b;
    tx_data_valid = 1'b1;
    tx_q.push_back(b);
    @(negedge clk);
    tx_data_valid = 1'b0;
    tx_data       = 8'($urandom);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input bit expect_it);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (expect_it) rx_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      if (i == 9) stop_centre_cyc = cyc + CYC / 2;
      repeat (CYC) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (!tx_data_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("tx_idle_wait", int'(tx_data_ready), 1);
  endtask

  initial begin
    logic [9:0] a5f;
    logic [7:0] rb;
    int diff;
    rst_n = 1'b1;
    rx_drv = 1'b1;
    loopback = 1'b0;
    tx_mon_en = 1'b0;
    rx_data_ready = 1'b1;
    tx_data = 8'h00;
    tx_data_valid = 1'b0;
    #3 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_tx_pin", int'(tx_pin), 1);
    check("reset_tx_ready", int'(tx_data_ready), 1);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_data_valid), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset asserted in the middle of a transmission
    tx_data = 8'h5A;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    repeat (400) @(negedge clk);
    check("midtx_pin_low", int'(tx_pin), 0);
    check("midtx_busy", int'(tx_data_ready), 0);
    rst_n = 1'b0;
    #1;
    check("midtx_reset_pin", int'(tx_pin), 1);
    check("midtx_reset_ready", int'(tx_data_ready), 1);
    check("midtx_reset_rx_valid", int'(rx_data_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_pin", int'(tx_pin), 1);
    tx_mon_en = 1'b1;

    // Exact TX waveform for 0xA5, with a busy-time offer and data change that must be ignored
    a5f = {1'b1, 8'hA5, 1'b0};
    tx_data = 8'hA5;
    tx_data_valid = 1'b1;
    tx_q.push_back(8'hA5);
    @(negedge clk);
    tx_data_valid = 1'b0;
    tx_data = 8'h00;
    for (int c = 0; c <= 10 * CYC; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1000) begin
        tx_data = 8'hFF;
        tx_data_valid = 1'b1;
      end
      if (c == 1001) tx_data_valid = 1'b0;
      if (c < 10 * CYC && (c % CYC == 0 || c % CYC == CYC - 1))
        check("tx_a5_bit", int'(tx_pin), int'(a5f[c / CYC]));
      if (c == 0 || c == 10 * CYC - 1) check("tx_a5_busy", int'(tx_data_ready), 0);
      if (c == 10 * CYC) check("tx_a5_ready_back", int'(tx_data_ready), 1);
    end
    repeat (20) @(negedge clk);

    // RX 0x3C with latency and pulse-width checks
    rx_frame(8'h3C, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("rx_3c_drained", int'(rx_q.size()), 0);
    diff = valid_rise_cyc - stop_centre_cyc;
    check("rx_3c_latency_window", int'(diff >= 1 && diff <= 5), 1);
    check("rx_3c_pulse_len", last_pulse_len, 1);

    // Short glitch must not produce a byte; the next frame must
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    rx_drv = 1'b1;
    repeat (500) @(negedge clk);
    rx_frame(8'h81, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("rx_glitch_81_drained", int'(rx_q.size()), 0);

    // Framing error discards the byte; recovery on the following frame
    rx_frame(8'hF0, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    rx_frame(8'h55, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("rx_frame_err_55_drained", int'(rx_q.size()), 0);

    // Loopback with host stalled: first byte held, second lost
    rx_data_ready = 1'b0;
    loopback = 1'b1;
    rx_q.push_back(8'h00);
    tx_send(8'h00);
    tx_send(8'hFF);
    wait_tx_idle();
    repeat (20) @(negedge clk);
    check("lb_valid_held", int'(rx_data_valid), 1);
    check("lb_data_held", int'(rx_data), 8'h00);
    rx_data_ready = 1'b1;
    @(negedge clk);
    check("lb_valid_cleared", int'(rx_data_valid), 0);
    check("lb_data_kept", int'(rx_data), 8'h00);
    check("lb_drained", int'(rx_q.size()), 0);
    repeat (20) @(negedge clk);
    loopback = 1'b0;

    // Random bytes on both directions concurrently
    fork
      begin
        for (int i = 0; i < 6; i++) tx_send(8'($urandom));
      end
      begin
        for (int j = 0; j < 6; j++) begin
          repeat ($urandom_range(5, 300)) @(negedge clk);
          rb = 8'($urandom);
          rx_frame(rb, 1'b1, 1'b1);
        end
      end
    join
    wait_tx_idle();
    repeat (20) @(negedge clk);
    check("final_tx_drained", int'(tx_q.size()), 0);
    check("final_rx_drained", int'(rx_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
